// File: rtl/nios_lcd_pkg.sv
// Shared constants, FSM states and sizing helper for the LCD write engine.
// Optional interrupt support is built when NIOS_LCD_IRQ_EN is defined.
package nios_lcd_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_CMD    = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_CTRL   = 2'd3;

   localparam int ST_BUSY    = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_OVF     = 2;
   localparam int ST_LVL_LSB = 8;

   localparam int CT_IRQ_EN = 0;
   localparam int CT_FLUSH  = 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_PULSE,
      S_HOLD,
      S_GAP
   } state_e;

   function automatic int max4(input int a, input int b,
                               input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/nios_lcd_ctrl_if.sv
// Avalon-MM slave bus bundle for the LCD controller.
// master drives requests, slave returns readdata.
interface nios_lcd_ctrl_if;
   import nios_lcd_pkg::*;

   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic        read_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, read_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, read_n, writedata,
      output readdata
   );

endinterface

// File: rtl/nios_lcd_fifo.sv
// Synchronous FIFO with flush; a push while full or during flush is dropped.
// Pointers wrap naturally, level carries one extra bit.
module nios_lcd_fifo
   import nios_lcd_pkg::*;
#(
   parameter int W     = 9,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push_i,
   input  logic [W-1:0]               data_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [W-1:0]               data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [LW-1:0] level_q;
   logic          do_push, do_pop;

   assign full_o  = (level_q == FULL_LVL);
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign data_o  = mem_q[rd_q];

   assign do_push = push_i & ~full_o & ~flush_i;
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else if (flush_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/nios_lcd_ctrl.sv
// Avalon-MM LCD write engine: FIFO plus self-timed E/RS/data FSM.
// Define NIOS_LCD_IRQ_EN to build the idle interrupt and its enable bit.
module nios_lcd_ctrl
   import nios_lcd_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int SETUP_CYC  = 3,
   parameter int PULSE_CYC  = 24,
   parameter int HOLD_CYC   = 3,
   parameter int GAP_CYC    = 2000
) (
   input  logic               clk,
   input  logic               reset_n,
   nios_lcd_ctrl_if.slave     bus,
   output logic [DATA_W-1:0]  lcd_data,
   output logic               lcd_rs,
   output logic               lcd_e,
   output logic               irq
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int CW =
      $clog2(max4(SETUP_CYC, PULSE_CYC, HOLD_CYC, GAP_CYC) + 1);
   localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] LD_PULSE = CW'(PULSE_CYC - 1);
   localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] LD_GAP   = CW'(GAP_CYC - 1);

   logic              wr, wr_data, wr_cmd, wr_stat, wr_ctrl;
   logic              push, flush, pop;
   logic [DATA_W:0]   fifo_in, fifo_out;
   logic              full, empty, busy;
   logic [LW-1:0]     level;
   logic              ovf_q, ovf_d;
   logic              irq_en;
   logic              unused_ok;

   state_e            state_q;
   logic [CW-1:0]     cnt_q;
   logic              tc;
   logic [DATA_W-1:0] lcd_data_q;
   logic              lcd_rs_q, lcd_e_q;

   assign wr      = bus.chipselect & ~bus.write_n;
   assign wr_data = wr & (bus.address == ADDR_DATA);
   assign wr_cmd  = wr & (bus.address == ADDR_CMD);
   assign wr_stat = wr & (bus.address == ADDR_STATUS);
   assign wr_ctrl = wr & (bus.address == ADDR_CTRL);

   assign push    = wr_data | wr_cmd;
   assign flush   = wr_ctrl & bus.writedata[CT_FLUSH];
   assign fifo_in = {wr_data, bus.writedata[DATA_W-1:0]};
   assign pop     = (state_q == S_IDLE) & ~empty;
   assign busy    = (state_q != S_IDLE) | ~empty;
   assign tc      = (cnt_q == '0);

   assign unused_ok = ^{bus.read_n, bus.writedata};

   nios_lcd_fifo #(
      .W     (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (push),
      .data_i  (fifo_in),
      .pop_i   (pop),
      .flush_i (flush),
      .data_o  (fifo_out),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level)
   );

   // Flushed pushes are silently dropped; only a genuine full drop is sticky.
   always_comb begin
      ovf_d = ovf_q;
      if (wr_stat && bus.writedata[ST_OVF]) ovf_d = 1'b0;
      if (push && full && !flush)           ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ovf_q <= 1'b0;
      else          ovf_q <= ovf_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         lcd_data_q <= '0;
         lcd_rs_q   <= 1'b0;
         lcd_e_q    <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (!empty) begin
                  lcd_data_q <= fifo_out[DATA_W-1:0];
                  lcd_rs_q   <= fifo_out[DATA_W];
                  cnt_q      <= LD_SETUP;
                  state_q    <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (tc) begin
                  lcd_e_q <= 1'b1;
                  cnt_q   <= LD_PULSE;
                  state_q <= S_PULSE;
               end else cnt_q <= cnt_q - CW'(1);
            end
            S_PULSE: begin
               if (tc) begin
                  lcd_e_q <= 1'b0;
                  cnt_q   <= LD_HOLD;
                  state_q <= S_HOLD;
               end else cnt_q <= cnt_q - CW'(1);
            end
            S_HOLD: begin
               if (tc) begin
                  cnt_q   <= LD_GAP;
                  state_q <= S_GAP;
               end else cnt_q <= cnt_q - CW'(1);
            end
            S_GAP: begin
               if (tc) state_q <= S_IDLE;
               else    cnt_q   <= cnt_q - CW'(1);
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign lcd_data = lcd_data_q;
   assign lcd_rs   = lcd_rs_q;
   assign lcd_e    = lcd_e_q;

`ifdef NIOS_LCD_IRQ_EN
   logic irq_en_q, irq_q;

   // A push drops irq on the very next cycle, before busy is visible.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         if (wr_ctrl) irq_en_q <= bus.writedata[CT_IRQ_EN];
         irq_q <= irq_en_q & ~busy & ~push;
      end
   end

   assign irq_en = irq_en_q;
   assign irq    = irq_q;
`else
   assign irq_en = 1'b0;
   assign irq    = 1'b0;
`endif

   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         ADDR_DATA: bus.readdata[DATA_W-1:0] = lcd_data_q;
         ADDR_STATUS: begin
            bus.readdata[ST_BUSY]          = busy;
            bus.readdata[ST_FULL]          = full;
            bus.readdata[ST_OVF]           = ovf_q;
            bus.readdata[ST_LVL_LSB +: LW] = level;
         end
         ADDR_CTRL: bus.readdata[CT_IRQ_EN] = irq_en;
         default:   bus.readdata = '0;
      endcase
   end

endmodule
